cache_req_ctrl: RTL and testbench

//  Request sequencer directly upstream of the cache memory block. Accepts GET/PUT requests
//  on a valid/ready port, performs a lookup, issues at most one single-cycle write, and returns
//  one response per request on a valid/ready port. Keeps keys unique and tracks occupancy.

---
 rtl/cache_req_ctrl.sv | 145 ++++++++++++++
 tb/tb_cache_req_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_ctrl.sv
// Purpose: GET/PUT request sequencer in front of the cache memory block; optional stats counters under CACHE_CTRL_STATS_EN.
// Latency: accept to rsp_valid is 1 cycle (illegal op), 2 cycles (GET/DUP/FULL), 3 cycles (PUT OK).
// Backpressure: one request in flight; req_ready only in IDLE, response held until rsp_ready.
module cache_req_ctrl #(
    parameter int NUM_ENTRIES = 16,
    parameter int KEY_WIDTH   = 16,
    parameter int VALUE_WIDTH = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [1:0]                         req_op,
    input  logic [KEY_WIDTH-1:0]               req_key,
    input  logic [VALUE_WIDTH-1:0]             req_value,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [1:0]                         rsp_status,
    output logic [VALUE_WIDTH-1:0]             rsp_value,
    output logic [1:0]                         mem_op,
    output logic [KEY_WIDTH-1:0]               mem_key,
    output logic [VALUE_WIDTH-1:0]             mem_value,
    input  logic [VALUE_WIDTH-1:0]             mem_value_out,
    input  logic                               mem_hit,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [31:0]                        stat_hits,
    output logic [31:0]                        stat_misses,
    output logic [31:0]                        stat_puts
`endif
);

    localparam int OCC_W = $clog2(NUM_ENTRIES + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(NUM_ENTRIES);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOOKUP = 2'd1;
    localparam logic [1:0] WRITE  = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [1:0] OP_GET = 2'b01;
    localparam logic [1:0] OP_PUT = 2'b10;

    localparam logic [1:0] ST_OK   = 2'd0;
    localparam logic [1:0] ST_MISS = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;
    localparam logic [1:0] ST_DUP  = 2'd3;

    logic [1:0]             state;
    logic [1:0]             op_q;
    logic [KEY_WIDTH-1:0]   key_q;
    logic [VALUE_WIDTH-1:0] val_q;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign mem_key   = key_q;
    assign mem_value = val_q;

    // Write strobe lasts exactly one cycle: the memory block fills a new cell on every PUT cycle.
    always_comb begin
        mem_op = 2'b00;
        if (state == LOOKUP)
            mem_op = OP_GET;
        else if (state == WRITE)
            mem_op = OP_PUT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= 2'b00;
            key_q      <= '0;
            val_q      <= '0;
            rsp_status <= ST_OK;
            rsp_value  <= '0;
            occupancy  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q  <= req_op;
                        key_q <= req_key;
                        val_q <= req_value;
                        if (req_op == OP_GET || req_op == OP_PUT) begin
                            state <= LOOKUP;
                        end else begin
                            rsp_status <= ST_MISS;
                            rsp_value  <= '0;
                            state      <= RESP;
                        end
                    end
                end
                LOOKUP: begin
                    if (op_q == OP_GET) begin
                        rsp_status <= mem_hit ? ST_OK : ST_MISS;
                        rsp_value  <= mem_hit ? mem_value_out : '0;
                        state      <= RESP;
                    end else if (mem_hit) begin
                        // An existing key wins over a full table so callers learn the key is present.
                        rsp_status <= ST_DUP;
                        rsp_value  <= '0;
                        state      <= RESP;
                    end else if (occupancy == OCC_FULL) begin
                        rsp_status <= ST_FULL;
                        rsp_value  <= '0;
                        state      <= RESP;
                    end else begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    rsp_status <= ST_OK;
                    rsp_value  <= '0;
                    if (occupancy != OCC_FULL)
                        occupancy <= occupancy + 1'b1;
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_valid && rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_puts   <= '0;
        end else begin
            if (state == LOOKUP && op_q == OP_GET && mem_hit && stat_hits != 32'hFFFF_FFFF)
                stat_hits <= stat_hits + 32'd1;
            if (state == LOOKUP && op_q == OP_GET && !mem_hit && stat_misses != 32'hFFFF_FFFF)
                stat_misses <= stat_misses + 32'd1;
            if (state == WRITE && stat_puts != 32'hFFFF_FFFF)
                stat_puts <= stat_puts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_req_ctrl.sv
// Directed bench for cache_req_ctrl with a behavioural key/value memory block.
module tb_cache_req_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_key;
    logic [63:0] req_value;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_status;
    logic [63:0] rsp_value;
    logic [1:0]  mem_op;
    logic [15:0] mem_key;
    logic [63:0] mem_value;
    logic [63:0] mem_value_out;
    logic        mem_hit;
    logic [4:0]  occupancy;
`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
    logic [31:0] stat_puts;
`endif

    int n_vec = 0;
    int n_err = 0;

    cache_req_ctrl #(.NUM_ENTRIES(16), .KEY_WIDTH(16), .VALUE_WIDTH(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_key       (req_key),
        .req_value     (req_value),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_status    (rsp_status),
        .rsp_value     (rsp_value),
        .mem_op        (mem_op),
        .mem_key       (mem_key),
        .mem_value     (mem_value),
        .mem_value_out (mem_value_out),
        .mem_hit       (mem_hit),
        .occupancy     (occupancy)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .stat_hits     (stat_hits),
        .stat_misses   (stat_misses),
        .stat_puts     (stat_puts)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory block model: one new cell per PUT cycle, combinational lookup, cleared with rst.
    logic [15:0] m_key [16];
    logic [63:0] m_val [16];
    logic        m_vld [16];
    logic [4:0]  m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) m_vld[i] <= 1'b0;
            m_cnt <= 5'd0;
        end else if (mem_op == 2'b10 && m_cnt < 5'd16) begin
            m_key[m_cnt[3:0]] <= mem_key;
            m_val[m_cnt[3:0]] <= mem_value;
            m_vld[m_cnt[3:0]] <= 1'b1;
            m_cnt <= m_cnt + 5'd1;
        end
    end

    always_comb begin
        mem_hit       = 1'b0;
        mem_value_out = 64'd0;
        for (int i = 0; i < 16; i++) begin
            if (m_vld[i] === 1'b1 && m_key[i] == mem_key) begin
                mem_hit       = 1'b1;
                mem_value_out = m_val[i];
            end
        end
    end

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_key   = 16'd0;
        req_value = 64'd0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Issues one request from IDLE and observes it; lat = 99 means no response arrived.
    task automatic send_req(input logic [1:0] op, input logic [15:0] key, input logic [63:0] val,
                            input int hold, output int lat, output logic [1:0] st,
                            output logic [63:0] v, output int nwr, output int nacc,
                            output logic stable, output logic rdy_low);
        lat = 0; nwr = 0; nacc = 0; stable = 1'b1; rdy_low = 1'b1; st = 2'b00; v = 64'd0;
        @(negedge clk);
        req_op = op; req_key = key; req_value = val; req_valid = 1'b1;
        rsp_ready = (hold == 0);
        @(posedge clk);
        #1 req_valid = 1'b0; req_op = 2'b00;
        lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            if (rsp_valid) break;
            if (mem_op == 2'b10) nwr++;
            if (mem_op != 2'b00) nacc++;
            @(posedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            lat = 99;
            rsp_ready = 1'b1;
            return;
        end
        st = rsp_status;
        v  = rsp_value;
        if (req_ready) rdy_low = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_status !== st || rsp_value !== v) stable = 1'b0;
            if (req_ready) rdy_low = 1'b0;
            if (mem_op != 2'b00) nacc++;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_vec++; if (rsp_status !== 2'd0) begin n_err++; $display("FAIL reset_rsp_status got %0d want 0", rsp_status); end
        n_vec++; if (rsp_value !== 64'd0) begin n_err++; $display("FAIL reset_rsp_value got %h want 0", rsp_value); end
        n_vec++; if (mem_op !== 2'b00) begin n_err++; $display("FAIL reset_mem_op got %b want 00", mem_op); end
        n_vec++; if (mem_key !== 16'd0 || mem_value !== 64'd0) begin n_err++; $display("FAIL reset_mem_kv got %h/%h want 0/0", mem_key, mem_value); end
        n_vec++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
`ifdef CACHE_CTRL_STATS_EN
        n_vec++; if (stat_hits !== 32'd0 || stat_misses !== 32'd0 || stat_puts !== 32'd0) begin
            n_err++; $display("FAIL reset_stats got %0d/%0d/%0d want 0/0/0", stat_hits, stat_misses, stat_puts); end
`endif
    endtask

    task automatic test_put();
        int lat, nwr, nacc; logic [1:0] st; logic [63:0] v; logic stb, rl;
        send_req(2'b10, 16'h00A1, 64'hDEAD_BEEF, 0, lat, st, v, nwr, nacc, stb, rl);
        n_vec++; if (lat != 3) begin n_err++; $display("FAIL put_latency got %0d want 3", lat); end
        n_vec++; if (st !== 2'd0) begin n_err++; $display("FAIL put_status got %0d want 0", st); end
        n_vec++; if (nwr != 1) begin n_err++; $display("FAIL put_write_cycles got %0d want 1", nwr); end
        n_vec++; if (occupancy !== 5'd1) begin n_err++; $display("FAIL put_occupancy got %0d want 1", occupancy); end
        n_vec++; if (mem_key !== 16'h00A1 || mem_value !== 64'hDEAD_BEEF) begin
            n_err++; $display("FAIL put_mem_hold got %h/%h want 00a1/deadbeef", mem_key, mem_value); end
    endtask

    task automatic test_get();
        int lat, nwr, nacc; logic [1:0] st; logic [63:0] v; logic stb, rl;
        send_req(2'b01, 16'h00A1, 64'd0, 0, lat, st, v, nwr, nacc, stb, rl);
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL get_hit_latency got %0d want 2", lat); end
        n_vec++; if (st !== 2'd0) begin n_err++; $display("FAIL get_hit_status got %0d want 0", st); end
        n_vec++; if (v !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL get_hit_value got %h want deadbeef", v); end
        send_req(2'b01, 16'h00B2, 64'd0, 0, lat, st, v, nwr, nacc, stb, rl);
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL get_miss_latency got %0d want 2", lat); end
        n_vec++; if (st !== 2'd1) begin n_err++; $display("FAIL get_miss_status got %0d want 1", st); end
        n_vec++; if (v !== 64'd0) begin n_err++; $display("FAIL get_miss_value got %h want 0", v); end
        n_vec++; if (nwr != 0) begin n_err++; $display("FAIL get_miss_writes got %0d want 0", nwr); end
`ifdef CACHE_CTRL_STATS_EN
        n_vec++; if (stat_hits !== 32'd1 || stat_misses !== 32'd1 || stat_puts !== 32'd1) begin
            n_err++; $display("FAIL get_stats got %0d/%0d/%0d want 1/1/1", stat_hits, stat_misses, stat_puts); end
`endif
    endtask

    task automatic test_dup();
        int lat, nwr, nacc; logic [1:0] st; logic [63:0] v; logic stb, rl;
        send_req(2'b10, 16'h00A1, 64'h1234, 0, lat, st, v, nwr, nacc, stb, rl);
        n_vec++; if (st !== 2'd3) begin n_err++; $display("FAIL dup_status got %0d want 3", st); end
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL dup_latency got %0d want 2", lat); end
        n_vec++; if (nwr != 0) begin n_err++; $display("FAIL dup_writes got %0d want 0", nwr); end
        n_vec++; if (occupancy !== 5'd1) begin n_err++; $display("FAIL dup_occupancy got %0d want 1", occupancy); end
    endtask

    task automatic test_illegal();
        int lat, nwr, nacc; logic [1:0] st; logic [63:0] v; logic stb, rl;
        send_req(2'b11, 16'h00A1, 64'h5555, 0, lat, st, v, nwr, nacc, stb, rl);
        n_vec++; if (lat != 1) begin n_err++; $display("FAIL illegal_latency got %0d want 1", lat); end
        n_vec++; if (st !== 2'd1 || v !== 64'd0) begin n_err++; $display("FAIL illegal_rsp got %0d/%h want 1/0", st, v); end
        n_vec++; if (nacc != 0) begin n_err++; $display("FAIL illegal_mem_access got %0d want 0", nacc); end
        send_req(2'b00, 16'h0001, 64'd0, 0, lat, st, v, nwr, nacc, stb, rl);
        n_vec++; if (lat != 1 || st !== 2'd1 || nacc != 0) begin
            n_err++; $display("FAIL illegal00 got lat %0d st %0d acc %0d want 1/1/0", lat, st, nacc); end
    endtask

    task automatic test_full();
        int lat, nwr, nacc; logic [1:0] st; logic [63:0] v; logic stb, rl;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            send_req(2'b10, 16'h0200 + 16'(i), 64'h1000_0000_0000_0000 + 64'(i), 0, lat, st, v, nwr, nacc, stb, rl);
            n_vec++; if (st !== 2'd0 || nwr != 1) begin n_err++; $display("FAIL fill_put%0d got st %0d wr %0d want 0/1", i, st, nwr); end
        end
        n_vec++; if (occupancy !== 5'd16) begin n_err++; $display("FAIL fill_occupancy got %0d want 16", occupancy); end
        send_req(2'b10, 16'h0FFF, 64'h77, 0, lat, st, v, nwr, nacc, stb, rl);
        n_vec++; if (st !== 2'd2) begin n_err++; $display("FAIL full_status got %0d want 2", st); end
        n_vec++; if (lat != 2 || nwr != 0) begin n_err++; $display("FAIL full_timing got lat %0d wr %0d want 2/0", lat, nwr); end
        n_vec++; if (occupancy !== 5'd16) begin n_err++; $display("FAIL full_occupancy got %0d want 16", occupancy); end
        send_req(2'b10, 16'h0203, 64'h88, 0, lat, st, v, nwr, nacc, stb, rl);
        n_vec++; if (st !== 2'd3 || nwr != 0) begin n_err++; $display("FAIL full_dup got st %0d wr %0d want 3/0", st, nwr); end
    endtask

    task automatic test_backpressure();
        int lat, nwr, nacc; logic [1:0] st; logic [63:0] v; logic stb, rl;
        send_req(2'b01, 16'h0205, 64'd0, 5, lat, st, v, nwr, nacc, stb, rl);
        n_vec++; if (st !== 2'd0 || v !== 64'h1000_0000_0000_0005) begin
            n_err++; $display("FAIL bp_rsp got %0d/%h want 0/1000000000000005", st, v); end
        n_vec++; if (stb !== 1'b1) begin n_err++; $display("FAIL bp_stable got %b want 1", stb); end
        n_vec++; if (rl !== 1'b1) begin n_err++; $display("FAIL bp_req_ready_low got %b want 1", rl); end
        n_vec++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_release got rdy %b vld %b want 1/0", req_ready, rsp_valid); end
    endtask

    task automatic test_reset_mid_write();
        int lat, nwr, nacc; logic [1:0] st; logic [63:0] v; logic stb, rl; logic seen;
        apply_reset();
        @(negedge clk);
        req_op = 2'b10; req_key = 16'h0777; req_value = 64'hABCD; req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0; req_op = 2'b00;
        @(posedge clk);
        @(negedge clk);
        n_vec++; if (mem_op !== 2'b10) begin n_err++; $display("FAIL rstw_in_write got %b want 10", mem_op); end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b1 || mem_op !== 2'b00) begin
            n_err++; $display("FAIL rstw_idle got rdy %b op %b want 1/00", req_ready, mem_op); end
        n_vec++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL rstw_occupancy got %0d want 0", occupancy); end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstw_no_rsp got %b want 0", seen); end
`ifdef CACHE_CTRL_STATS_EN
        n_vec++; if (stat_hits !== 32'd0 || stat_misses !== 32'd0 || stat_puts !== 32'd0) begin
            n_err++; $display("FAIL rstw_stats got %0d/%0d/%0d want 0/0/0", stat_hits, stat_misses, stat_puts); end
`endif
        send_req(2'b01, 16'h0777, 64'd0, 0, lat, st, v, nwr, nacc, stb, rl);
        n_vec++; if (st !== 2'd1) begin n_err++; $display("FAIL rstw_get_after got %0d want 1", st); end
    endtask

    initial begin
        test_reset();
        test_put();
        test_get();
        test_dup();
        test_illegal();
        test_full();
        test_backpressure();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
